vga_axil_regfile: RTL and testbench
===================================

VGA_AXIL_REGFILE -- requirements
Module: vga_axil_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI-Lite address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; legal range 1..256.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports awaddr in ADDR_W, awvalid in 1, awready out 1: write-address channel.
REQ-007 SHALL have ports wdata in DATA_W, wstrb in DATA_W/8, wvalid in 1, wready out 1: write-data channel.
REQ-008 SHALL have ports bresp out 2, bvalid out 1, bready in 1: write-response channel.
REQ-009 SHALL have ports araddr in ADDR_W, arvalid in 1, arready out 1: read-address channel.
REQ-010 SHALL have ports rdata out DATA_W, rresp out 2, rvalid out 1, rready in 1: read-data channel.
REQ-011 SHALL have port regs_o  out  NUM_REGS*DATA_W  live register contents; register i at bits [i*DATA_W +: DATA_W].

Function
REQ-012 SHALL decode register index as addr >> log2(DATA_W/8); low byte-offset bits ignored.
REQ-013 SHALL flag index >= NUM_REGS as out-of-range: resp SLVERR (2'b10), no write, rdata 0; in range: OKAY (2'b00).
REQ-014 SHALL run write FSM states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
REQ-015 W_IDLE: AW and W both handshaken -> W_RESP; only AW -> W_HAVE_A; only W -> W_HAVE_D.
REQ-016 W_HAVE_A: awready 0, wready 1; W handshake -> W_RESP. W_HAVE_D: wready 0, awready 1; AW handshake -> W_RESP.
REQ-017 SHALL commit the write on the edge entering W_RESP; bvalid 1 in the next cycle (1-cycle latency from the last handshake).
REQ-018 W_RESP: awready = wready = 0; bvalid && bready -> W_IDLE; bvalid held with bresp stable until accepted.
REQ-019 SHALL run read FSM states R_IDLE (arready 1), R_RESP (arready 0, rvalid 1); rdata/rresp registered on the AR handshake edge, held stable until rvalid && rready.
REQ-020 Read and write to the same register committing in the same cycle SHALL return the pre-write value.
REQ-021 Read and write channels SHALL be fully independent; neither stalls the other.
REQ-022 regs_o SHALL reflect a committed write in the cycle after the commit edge.

Reset
REQ-023 rst high at a clk edge SHALL clear all registers to 0, both FSMs to idle, bvalid/rvalid 0, bresp/rresp/rdata 0.
REQ-024 While rst is high, awready, wready and arready SHALL be 0; they go to 1 in the first cycle after rst falls.
REQ-025 rst mid-transaction SHALL drop any buffered address/data and pending response without committing it.

Configuration
REQ-026 Macro VGA_AXIL_REGFILE_WSTRB_EN defined: only byte lanes with wstrb[k]=1 are written; other bytes keep their value.
REQ-027 Macro VGA_AXIL_REGFILE_WSTRB_EN undefined: wstrb ignored; every accepted in-range write updates the full word.

Verification
REQ-028 AW+W same cycle, addr 0x8, data 0xDEADBEEF, bready 1 -> bvalid 1 cycle later, bresp OKAY, regs_o[2] = 0xDEADBEEF.
REQ-029 W at cycle 0, AW at cycle 3, addr 0x4, data 0x12345678 -> wready 0 on cycles 1-3, bvalid at cycle 4, read of 0x4 returns 0x12345678 OKAY.
REQ-030 Write addr 0x40 (NUM_REGS=16, DATA_W=32) -> bresp SLVERR, all regs unchanged; read 0x40 -> rresp SLVERR, rdata 0.
REQ-031 bready held 0 for 5 cycles after bvalid -> bvalid and bresp stable, awready/wready 0, exactly one write committed.
REQ-032 WSTRB_EN defined, reg 0 = 0xFFFFFFFF, write 0x00000000 with wstrb 4'b0101 -> reg 0 = 0xFF00FF00; macro undefined -> 0x00000000.
REQ-033 rst pulsed in W_HAVE_A -> no commit, bvalid 0, all regs 0, awready/wready 1 in first cycle after rst falls.

Source files
------------

// File: rtl/vga_axil_regfile.sv
// vga_axil_regfile: AXI4-Lite slave backed by a flat array of NUM_REGS
// registers of DATA_W bits. Every register is also visible in parallel on regs_o.
//
// Optional feature: define VGA_AXIL_REGFILE_WSTRB_EN to honour wstrb byte
// lanes on writes. When it is left undefined, wstrb is ignored and each
// accepted in-range write replaces the whole word.
//
// Handshake semantics, which apply to every channel (AW, W, B, AR, R):
// a transfer happens on a rising clk edge where valid && ready are both high.
// A source that raises valid holds it and its payload stable until that edge.
// The responses produced here (bvalid/bresp, rvalid/rdata/rresp) follow the
// same rule and never depend combinationally on bready or rready.
module vga_axil_regfile #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [1:0]                   dbg_w_state,
  output logic                         dbg_r_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFFS_W = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  // The register index is the address with its byte-offset bits dropped.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a >> OFFS_W) < ADDR_W'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFFS_W);
  endfunction

  logic [DATA_W-1:0] regs [NUM_REGS];

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic              aw_hs, w_hs, ar_hs;
  logic [ADDR_W-1:0] aw_buf;
  logic [DATA_W-1:0] w_buf;
  logic              commit_en;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [DATA_W-1:0] commit_word;

`ifdef VGA_AXIL_REGFILE_WSTRB_EN
  logic [STRB_W-1:0] strb_buf;
  logic [STRB_W-1:0] commit_strb;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
`endif

  // Write FSM next state, channel readies and the selection of which address
  // and data (live or buffered) are committed on the edge entering W_RESP.
  always_comb begin
    w_next      = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    commit_en   = 1'b0;
    commit_addr = awaddr;
    commit_data = wdata;
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
    commit_strb = wstrb;
`endif
    case (w_state)
      W_IDLE:   begin awready = !rst; wready = !rst; end
      W_HAVE_A: wready  = !rst;
      W_HAVE_D: awready = !rst;
      default:  ;
    endcase
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_next    = W_RESP;
          commit_en = 1'b1;
        end else if (aw_hs) begin
          w_next = W_HAVE_A;
        end else if (w_hs) begin
          w_next = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          w_next      = W_RESP;
          commit_en   = 1'b1;
          commit_addr = aw_buf;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          w_next      = W_RESP;
          commit_en   = 1'b1;
          commit_data = w_buf;
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
          commit_strb = strb_buf;
`endif
        end
      end
      W_RESP: begin
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign bvalid = (w_state == W_RESP);

  // Merge the incoming data with the current word according to the byte strobes.
  always_comb begin
    commit_word = commit_data;
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
    for (int k = 0; k < STRB_W; k++) begin
      if (!commit_strb[k])
        commit_word[8*k +: 8] = regs[addr_idx(commit_addr)][8*k +: 8];
    end
`endif
  end

  // Write FSM state, half-transaction buffers and the write response code.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_buf  <= '0;
      w_buf   <= '0;
      bresp   <= RESP_OKAY;
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
      strb_buf <= '0;
`endif
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_buf <= awaddr;
      if (w_hs) begin
        w_buf <= wdata;
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
        strb_buf <= wstrb;
`endif
      end
      if (commit_en) bresp <= addr_ok(commit_addr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Register array: cleared on reset, updated only by an in-range commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_en && addr_ok(commit_addr)) begin
      regs[addr_idx(commit_addr)] <= commit_word;
    end
  end

  // Read FSM next state and channel handshake signals.
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = !rst;
        if (arvalid && !rst) r_next = R_RESP;
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
    ar_hs = arvalid && arready;
  end

  // Read FSM state and the read response captured on the AR handshake edge;
  // a write committing on the same edge is not yet visible here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        if (addr_ok(araddr)) begin
          rdata <= regs[addr_idx(araddr)];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Flatten the register array onto the parallel output bus.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

  assign dbg_w_state = w_state;
  assign dbg_r_state = r_state;

endmodule

// File: tb/tb_vga_axil_regfile.sv
// tb_vga_axil_regfile: directed testbench for vga_axil_regfile (default
// parameters). Inputs change 1 time unit after a rising edge; outputs are
// sampled on the falling edge.
module tb_vga_axil_regfile;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  logic                       clk;
  logic                       rst;
  logic [ADDR_W-1:0]          awaddr;
  logic                       awvalid;
  logic                       awready;
  logic [DATA_W-1:0]          wdata;
  logic [DATA_W/8-1:0]        wstrb;
  logic                       wvalid;
  logic                       wready;
  logic [1:0]                 bresp;
  logic                       bvalid;
  logic                       bready;
  logic [ADDR_W-1:0]          araddr;
  logic                       arvalid;
  logic                       arready;
  logic [DATA_W-1:0]          rdata;
  logic [1:0]                 rresp;
  logic                       rvalid;
  logic                       rready;
  logic [NUM_REGS*DATA_W-1:0] regs_o;
  logic [1:0]                 dbg_w_state;
  logic                       dbg_r_state;

  logic [DATA_W-1:0] exp_regs [NUM_REGS];
  logic [DATA_W-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  vga_axil_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_REGS*DATA_W-1:0] model_vec();
    logic [NUM_REGS*DATA_W-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = exp_regs[i];
    return v;
  endfunction

  // Driver: AW and W in the same cycle with bready high; reports the response.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W/8-1:0] s, output logic seen, output logic [1:0] r);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    seen = bvalid; r = bresp;
    @(posedge clk); #1;
  endtask

  // Driver: single read with rready high; reports the response.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic seen,
                         output logic [DATA_W-1:0] d, output logic [1:0] r);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    seen = rvalid; d = rdata; r = rresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_err++; $display("FAIL reset_readies: got %b, expected 000", {awready, wready, arready});
    end
    n_vec++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
      n_err++; $display("FAIL reset_resp: got %b, expected 000000", {bvalid, rvalid, bresp, rresp});
    end
    n_vec++;
    if (rdata !== '0) begin
      n_err++; $display("FAIL reset_rdata: got %h, expected 0", rdata);
    end
    n_vec++;
    if (regs_o !== '0) begin
      n_err++; $display("FAIL reset_regs: got %h, expected 0", regs_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_err++; $display("FAIL reset_release_readies: got %b, expected 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_aw_w_same();
    awaddr = 32'h8; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({awready, wready} !== 2'b11) begin
      n_err++; $display("FAIL same_readies: got %b, expected 11", {awready, wready});
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    exp_regs[2] = 32'hDEADBEEF;
    @(negedge clk);
    n_vec++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_err++; $display("FAIL same_bresp: got bvalid=%b bresp=%b, expected 1 00", bvalid, bresp);
    end
    n_vec++;
    if ({awready, wready} !== 2'b00) begin
      n_err++; $display("FAIL same_resp_readies: got %b, expected 00", {awready, wready});
    end
    n_vec++;
    if (regs_o !== model_vec()) begin
      n_err++; $display("FAIL same_regs: got %h, expected %h", regs_o, model_vec());
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (bvalid !== 1'b0) begin
      n_err++; $display("FAIL same_bvalid_drop: got %b, expected 0", bvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_split();
    logic seen; logic [DATA_W-1:0] d; logic [1:0] r;
    bready = 1'b1; awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
    @(negedge clk);
    n_vec++;
    if (wready !== 1'b1) begin
      n_err++; $display("FAIL split_wready_c0: got %b, expected 1", wready);
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wdata = 32'hFFFF0000;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin awaddr = 32'h4; awvalid = 1'b1; end
      @(negedge clk);
      n_vec++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
        n_err++;
        $display("FAIL split_wait_c%0d: got wready=%b awready=%b bvalid=%b, expected 0 1 0", c, wready, awready, bvalid);
      end
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    exp_regs[1] = 32'h12345678;
    @(negedge clk);
    n_vec++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_err++; $display("FAIL split_bvalid_c4: got bvalid=%b bresp=%b, expected 1 00", bvalid, bresp);
    end
    @(posedge clk); #1;
    do_read(32'h4, seen, d, r);
    n_vec++;
    if (seen !== 1'b1 || d !== 32'h12345678 || r !== 2'b00) begin
      n_err++; $display("FAIL split_read: got rvalid=%b rdata=%h rresp=%b, expected 1 12345678 00", seen, d, r);
    end
  endtask

  task automatic test_out_of_range();
    logic seen; logic [DATA_W-1:0] d; logic [1:0] r;
    do_write(32'h40, 32'hCAFEF00D, 4'hF, seen, r);
    n_vec++;
    if (seen !== 1'b1 || r !== 2'b10) begin
      n_err++; $display("FAIL oor_bresp: got bvalid=%b bresp=%b, expected 1 10", seen, r);
    end
    n_vec++;
    if (regs_o !== model_vec()) begin
      n_err++; $display("FAIL oor_regs: got %h, expected %h", regs_o, model_vec());
    end
    do_read(32'h40, seen, d, r);
    n_vec++;
    if (seen !== 1'b1 || d !== '0 || r !== 2'b10) begin
      n_err++; $display("FAIL oor_read: got rvalid=%b rdata=%h rresp=%b, expected 1 0 10", seen, d, r);
    end
    // Last register, addressed with nonzero byte-offset bits.
    do_write(32'h3F, 32'hA5A50F0F, 4'hF, seen, r);
    exp_regs[15] = 32'hA5A50F0F;
    n_vec++;
    if (seen !== 1'b1 || r !== 2'b00) begin
      n_err++; $display("FAIL last_bresp: got bvalid=%b bresp=%b, expected 1 00", seen, r);
    end
    do_read(32'h3C, seen, d, r);
    n_vec++;
    if (seen !== 1'b1 || d !== 32'hA5A50F0F || r !== 2'b00) begin
      n_err++; $display("FAIL last_read: got rvalid=%b rdata=%h rresp=%b, expected 1 a5a50f0f 00", seen, d, r);
    end
  endtask

  task automatic test_backpressure();
    awaddr = 32'hC; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    exp_regs[3] = 32'h11111111;
    // Keep a second write offered; it must not be taken while the response waits.
    awaddr = 32'h10; wdata = 32'h22222222;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_c%0d: got bvalid=%b bresp=%b awready=%b wready=%b, expected 1 00 0 0",
                 c, bvalid, bresp, awready, wready);
      end
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (bvalid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: got bvalid=%b, expected 0", bvalid);
    end
    n_vec++;
    if (regs_o !== model_vec()) begin
      n_err++; $display("FAIL bp_regs: got %h, expected %h", regs_o, model_vec());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_during_write();
    logic seen; logic [DATA_W-1:0] d; logic [1:0] r;
    logic [DATA_W-1:0] old_val;
    old_val = exp_regs[2];
    araddr = 32'h8; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h8; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    exp_regs[2] = 32'h55AA55AA;
    @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== old_val) begin
      n_err++; $display("FAIL rw_same_rdata: got rvalid=%b rdata=%h, expected 1 %h", rvalid, rdata, old_val);
    end
    n_vec++;
    if (regs_o[2*DATA_W +: DATA_W] !== exp_regs[2]) begin
      n_err++; $display("FAIL rw_same_reg: got %h, expected %h", regs_o[2*DATA_W +: DATA_W], exp_regs[2]);
    end
    @(posedge clk); #1;
    // Read completes while a write response is still being held off.
    awaddr = 32'h18; wdata = 32'h0BADCAFE; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    exp_regs[6] = 32'h0BADCAFE;
    do_read(32'h18, seen, d, r);
    n_vec++;
    if (seen !== 1'b1 || d !== 32'h0BADCAFE || r !== 2'b00) begin
      n_err++; $display("FAIL indep_read: got rvalid=%b rdata=%h rresp=%b, expected 1 0badcafe 00", seen, d, r);
    end
    @(negedge clk);
    n_vec++;
    if (bvalid !== 1'b1) begin
      n_err++; $display("FAIL indep_bvalid: got %b, expected 1", bvalid);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wstrb();
    logic seen; logic [DATA_W-1:0] d; logic [1:0] r;
    logic [DATA_W-1:0] want;
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
    want = 32'hFF00FF00;
`else
    want = 32'h00000000;
`endif
    do_write(32'h0, 32'hFFFFFFFF, 4'hF, seen, r);
    do_write(32'h0, 32'h00000000, 4'b0101, seen, r);
    exp_regs[0] = want;
    n_vec++;
    if (regs_o[DATA_W-1:0] !== want) begin
      n_err++; $display("FAIL wstrb_reg0: got %h, expected %h", regs_o[DATA_W-1:0], want);
    end
    do_read(32'h0, seen, d, r);
    n_vec++;
    if (seen !== 1'b1 || d !== want) begin
      n_err++; $display("FAIL wstrb_read: got rvalid=%b rdata=%h, expected 1 %h", seen, d, want);
    end
  endtask

  task automatic test_back_to_back();
    logic seen; logic [DATA_W-1:0] d; logic [1:0] r;
    logic [DATA_W-1:0] tbl [4];
    tbl[0] = 32'h01234567; tbl[1] = 32'h89ABCDEF; tbl[2] = 32'hFEDCBA98; tbl[3] = 32'h76543210;
    for (int i = 0; i < 4; i++) begin
      do_write(ADDR_W'(32'h20 + 4 * i), tbl[i], 4'hF, seen, r);
      exp_regs[8 + i] = tbl[i];
      exp_q.push_back(tbl[i]);
    end
    for (int i = 0; i < 4; i++) begin
      logic [DATA_W-1:0] e;
      e = exp_q.pop_front();
      do_read(ADDR_W'(32'h20 + 4 * i), seen, d, r);
      n_vec++;
      if (seen !== 1'b1 || d !== e || r !== 2'b00) begin
        n_err++; $display("FAIL b2b_read_%0d: got rvalid=%b rdata=%h rresp=%b, expected 1 %h 00", i, seen, d, r, e);
      end
    end
    n_vec++;
    if (regs_o !== model_vec()) begin
      n_err++; $display("FAIL b2b_regs: got %h, expected %h", regs_o, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    bready = 1'b1; awaddr = 32'h14; awvalid = 1'b1; wvalid = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({awready, wready} !== 2'b01) begin
      n_err++; $display("FAIL mid_have_a: got awready,wready=%b, expected 01", {awready, wready});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_err++; $display("FAIL mid_rst_readies: got %b, expected 000", {awready, wready, arready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    @(negedge clk);
    n_vec++;
    if ({awready, wready, bvalid} !== 3'b110) begin
      n_err++; $display("FAIL mid_release: got awready,wready,bvalid=%b, expected 110", {awready, wready, bvalid});
    end
    n_vec++;
    if (regs_o !== '0) begin
      n_err++; $display("FAIL mid_regs_clear: got %h, expected 0", regs_o);
    end
    // A lone W beat now must wait for a fresh AW; the dropped address is gone.
    wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bvalid !== 1'b0 || regs_o !== '0) begin
      n_err++; $display("FAIL mid_no_commit: got bvalid=%b regs=%h, expected 0 0", bvalid, regs_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_aw_w_same();
    test_split();
    test_out_of_range();
    test_backpressure();
    test_read_during_write();
    test_wstrb();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
